sirv_tl_d_gather: RTL
=====================

Name: sirv_tl_d_gather

Overview:
- Response-side counterpart of the A-channel beat repeater.
- A request that was split into byte-wide fragments returns as several 8-bit TileLink D beats. This block collects those beats into one 32-bit D response.
- AccessAckData data bytes are packed little-endian; AccessAck is reduced to a single beat.
- Sits between the narrow peripheral-side D channel and the 32-bit core-side D channel.

Parameters:
- IN_W, 8: input data width in bits (one byte per beat).
- MAX_BEATS_LOG2, 2: log2 of the maximum number of beats gathered; output width is IN_W << MAX_BEATS_LOG2 = 32.
- SOURCE_W, 2: width of the source field.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- io_in_ready  out  1  input beat accepted when high together with io_in_valid.
- io_in_valid  in  1  narrow D beat valid.
- io_in_bits_opcode  in  3  0 = AccessAck, 1 = AccessAckData.
- io_in_bits_param  in  2  passed through.
- io_in_bits_size  in  3  log2 bytes of the whole response; constant across its beats.
- io_in_bits_source  in  SOURCE_W  constant across the beats of one response.
- io_in_bits_data  in  IN_W  beat data.
- io_in_bits_error  in  1  beat error flag.
- io_out_ready  in  1  downstream ready.
- io_out_valid  out  1  gathered response valid.
- io_out_bits_opcode  out  3  captured from the first beat.
- io_out_bits_param  out  2  captured from the first beat.
- io_out_bits_size  out  3  captured from the first beat.
- io_out_bits_source  out  SOURCE_W  captured from the first beat.
- io_out_bits_data  out  32  packed data.
- io_out_bits_error  out  1  OR of the error flags of all beats.
- io_busy  out  1  high while a response is partially gathered or held.

Behaviour:
- Reset (async, active-high): beat counter = 0, out_valid = 0, data register = 0, error accumulator = 0, captured fields = 0. Outputs at reset: io_out_valid = 0, io_busy = 0, io_in_ready = 1, all io_out_bits = 0.
- Beat count: nbeats = 1 << min(size, MAX_BEATS_LOG2), so size 0/1/2 gives 1/2/4 beats. A size above MAX_BEATS_LOG2 is clamped to 4 beats and its data is truncated to 32 bits.
- Handshake:
  - io_in_ready = !out_valid; there is no combinational in->out path.
  - An input fire is io_in_valid & io_in_ready.
  - An output fire is io_out_valid & io_out_ready.
- States: IDLE (cnt = 0, !out_valid), GATHER (cnt != 0), HOLD (out_valid).
- On an input fire when cnt == 0: capture opcode, param, size and source; clear the error accumulator to that beat's error; zero the data register; then write the byte.
- Byte write: for AccessAckData only, write data into byte lane cnt of the 32-bit register. For AccessAck the data register stays 0.
- Every input fire:
  - error_acc |= error.
  - If cnt == nbeats - 1: cnt <= 0 and out_valid <= 1 (enter HOLD) on the next edge.
  - Otherwise cnt <= cnt + 1.
- Latency: io_out_valid rises exactly 1 cycle after the last input beat is accepted.
- HOLD: io_out_valid stays high and io_out_bits stay stable until an output fire; the following cycle out_valid = 0 and io_in_ready = 1.
- Full throughput back-to-back is not required: a 1-cycle bubble per response is accepted.
- Unused byte lanes: lanes at index ≥ nbeats read 0. For size 0, out data = {24'b0, byte0}. No replication.
- io_busy = out_valid | (cnt != 0).
- Fields from the second and later beats (opcode, size, source) are ignored. Mismatches are not checked.
- Reset asserted mid-gather or in HOLD: all partial state is discarded immediately and no output is produced for that response.
- Counter width: MAX_BEATS_LOG2 bits; it never wraps past nbeats - 1.

Decomposition:
- Shared package: TileLink D opcode constants (ACCESS_ACK = 3'd0, ACCESS_ACK_DATA = 3'd1).
- Shared package: the MAX_BEATS_LOG2 default and a function computing beat count from size.
- One natural sub-module: sirv_tl_d_gather_lane, a byte-lane write-enable decoder plus data register.
- Everything else stays in the top module.

Test Plan:
- AccessAckData, size 2, source 1, data beats 0x11, 0x22, 0x33, 0x44, out_ready = 1 → 1 cycle after the 4th accept: out_valid = 1, data = 0x44332211, source = 1, size = 2, error = 0; out_valid falls the next cycle.
- AccessAck, size 1, 2 beats, error = 0 then 1 → single output: opcode = 0, data = 0, error = 1; exactly one out_valid pulse.
- AccessAckData, size 0, data 0xA5, out_ready held 0 for 5 cycles → out_valid = 1 and data = 0x000000A5 stable throughout; in_ready = 0 until the output fire, then 1.
- Two back-to-back size-1 responses with data 0x01, 0x02 then 0x03, 0x04, in_valid held high → outputs 0x00000201 then 0x00000403, in order, with no data mixing.
- Reset pulsed after 2 of 4 beats, then a full size-2 response 0xAA, 0xBB, 0xCC, 0xDD → no spurious output; after reset io_busy = 0; result = 0xDDCCBBAA.
- Size 3 (clamped) with beats 0x01, 0x02, 0x03, 0x04 → output after the 4th beat: data = 0x04030201, size field = 3.

Source files
------------

// File: rtl/sirv_tl_d_gather_pkg.sv
// Shared TileLink D-channel constants and beat-count helper for the D-channel gatherer.
package sirv_tl_d_gather_pkg;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  localparam int MAX_BEATS_LOG2_DEF = 2;
  localparam int SOURCE_W_DEF       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Oversized responses clamp to the widest gather; their upper bytes are dropped.
  function automatic int beat_count(input logic [2:0] size, input int max_log2);
    int s;
    s = (int'(size) > max_log2) ? max_log2 : int'(size);
    return 1 << s;
  endfunction

endpackage

// File: rtl/sirv_tl_d_gather_if.sv
// One TileLink D channel (ready/valid plus bits), sized by data and source width.
interface sirv_tl_d_gather_if
  import sirv_tl_d_gather_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int SOURCE_W = SOURCE_W_DEF
) ();
  logic                ready;
  logic                valid;
  logic [2:0]          opcode;
  logic [1:0]          param;
  logic [2:0]          size;
  logic [SOURCE_W-1:0] source;
  logic [DATA_W-1:0]   data;
  logic                error;

  modport master (input ready, output valid, opcode, param, size, source, data, error);
  modport slave  (output ready, input valid, opcode, param, size, source, data, error);
endinterface

// File: rtl/sirv_tl_d_gather_lane.sv
// Byte-lane write decoder and packed data register for the D-channel gatherer.
module sirv_tl_d_gather_lane
  import sirv_tl_d_gather_pkg::*;
#(
  parameter int IN_W           = 8,
  parameter int MAX_BEATS_LOG2 = MAX_BEATS_LOG2_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              clr,
  input  logic                              we,
  input  logic [MAX_BEATS_LOG2-1:0]         lane,
  input  logic [IN_W-1:0]                   wdata,
  output logic [(IN_W<<MAX_BEATS_LOG2)-1:0] data
);
  localparam int NLANES = 1 << MAX_BEATS_LOG2;

  generate
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
      logic [IN_W-1:0] byte_reg;
      logic            hit;

      assign hit = we && (lane == MAX_BEATS_LOG2'(gi));

      // A first beat clears every lane it does not write, so stale bytes never leak.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          byte_reg <= '0;
        end else if (hit) begin
          byte_reg <= wdata;
        end else if (clr) begin
          byte_reg <= '0;
        end
      end

      assign data[gi*IN_W +: IN_W] = byte_reg;
    end
  endgenerate
endmodule

// File: rtl/sirv_tl_d_gather.sv
// Gathers byte-wide TileLink D beats into one 32-bit D response (little-endian packing).
module sirv_tl_d_gather
  import sirv_tl_d_gather_pkg::*;
#(
  parameter int IN_W           = 8,
  parameter int MAX_BEATS_LOG2 = MAX_BEATS_LOG2_DEF,
  parameter int SOURCE_W       = SOURCE_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  sirv_tl_d_gather_if.slave  io_in,
  sirv_tl_d_gather_if.master io_out,
  output logic               io_busy
);
  localparam int CW    = MAX_BEATS_LOG2;
  localparam int OUT_W = IN_W << MAX_BEATS_LOG2;

  state_t              state_reg;
  logic [CW-1:0]       cnt_reg;
  logic [2:0]          opcode_reg;
  logic [1:0]          param_reg;
  logic [2:0]          size_reg;
  logic [SOURCE_W-1:0] source_reg;
  logic                error_reg;

  logic                in_fire;
  logic                out_fire;
  logic                first_beat;
  logic                last_beat;
  logic                is_data;
  logic [2:0]          cur_size;
  logic [CW-1:0]       last_idx;
  logic [OUT_W-1:0]    data_w;

  assign io_in.ready = (state_reg != ST_HOLD);
  assign in_fire     = io_in.valid && io_in.ready;
  assign out_fire    = io_out.valid && io_out.ready;
  assign first_beat  = (state_reg == ST_IDLE);

  // On the first beat the captured fields are not yet registered, so use the live ones.
  assign cur_size  = first_beat ? io_in.size : size_reg;
  assign last_idx  = CW'(beat_count(cur_size, MAX_BEATS_LOG2) - 1);
  assign last_beat = (cnt_reg == last_idx);
  assign is_data   = ((first_beat ? io_in.opcode : opcode_reg) == ACCESS_ACK_DATA);

  sirv_tl_d_gather_lane #(
    .IN_W           (IN_W),
    .MAX_BEATS_LOG2 (MAX_BEATS_LOG2)
  ) u_lane (
    .clock (clock),
    .reset (reset),
    .clr   (in_fire && first_beat),
    .we    (in_fire && is_data),
    .lane  (cnt_reg),
    .wdata (io_in.data),
    .data  (data_w)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      opcode_reg <= '0;
      param_reg  <= '0;
      size_reg   <= '0;
      source_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_fire) begin
            opcode_reg <= io_in.opcode;
            param_reg  <= io_in.param;
            size_reg   <= io_in.size;
            source_reg <= io_in.source;
            error_reg  <= io_in.error;
            if (last_beat) begin
              state_reg <= ST_HOLD;
            end else begin
              cnt_reg   <= cnt_reg + 1'b1;
              state_reg <= ST_GATHER;
            end
          end
        end
        ST_GATHER: begin
          if (in_fire) begin
            error_reg <= error_reg | io_in.error;
            if (last_beat) begin
              cnt_reg   <= '0;
              state_reg <= ST_HOLD;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_fire) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign io_out.valid  = (state_reg == ST_HOLD);
  assign io_out.opcode = opcode_reg;
  assign io_out.param  = param_reg;
  assign io_out.size   = size_reg;
  assign io_out.source = source_reg;
  assign io_out.data   = data_w;
  assign io_out.error  = error_reg;
  assign io_busy       = (state_reg != ST_IDLE);
endmodule
